// File: rtl/addsub_pipe.sv
// -----------------------------------------------------------------------------
// addsub_pipe -- two-stage pipelined two's-complement adder/subtractor with
// valid/ready handshakes on both sides, a sticky overflow flag and a count of
// delivered results.
//
// Stage 1 registers the operands (a, b, m). Stage 2 registers the result
// (s, overflow, carry). With no back-pressure a result is presented two
// cycles after its operands are accepted, and one operand set per cycle can
// stream through.
//
// Optional feature (compile-time macro ADDSUB_SAT_EN):
//   defined   -> s saturates to 0x7F..F / 0x80..0 on signed overflow
//                (overflow and carry still describe the unsaturated result)
//   undefined -> s is the wrapped modulo-2^WIDTH sum
//
// Ports:
//   clk         in   clock, all state on rising edge
//   rst_n       in   asynchronous active-low reset
//   in_valid    in   operand set presented
//   in_ready    out  operand set accepted this cycle when in_valid is high
//   m           in   0 = a + b, 1 = a - b
//   a, b        in   WIDTH-bit two's-complement operands
//   out_valid   out  result presented
//   out_ready   in   consumer takes the result this cycle
//   s           out  WIDTH-bit result
//   overflow    out  signed overflow of the presented result
//   carry       out  unsigned carry-out (subtract: 1 = no borrow)
//   clr_sticky  in   clears sticky_ovf
//   sticky_ovf  out  set by any delivered result that overflowed
//   op_count    out  16-bit wrapping count of delivered results
// -----------------------------------------------------------------------------
module addsub_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             m,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             overflow,
    output logic             carry,
    input  logic             clr_sticky,
    output logic             sticky_ovf,
    output logic [15:0]      op_count
);

    // Stage 1: operand registers
    logic             s1_valid_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             m_reg;

    // Stage 2: result registers
    logic             s2_valid_reg;
    logic [WIDTH-1:0] s_reg;
    logic             ovf_reg;
    logic             carry_reg;

    logic             sticky_reg;
    logic [15:0]      count_reg;

    // Handshake / advance control
    logic s2_load;
    logic s1_load;
    logic out_xfer;

    // Stage-2 next values
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum_full;
    logic [WIDTH-1:0] sum_next;
    logic             carry_next;
    logic             ovf_next;
    logic [WIDTH-1:0] s_next;

    // A stage may load when it is empty or its contents move on this cycle.
    assign s2_load  = !s2_valid_reg || out_ready;
    assign s1_load  = !s1_valid_reg || s2_load;
    assign in_ready = s1_load;
    assign out_xfer = s2_valid_reg && out_ready;

    // Subtraction as a + ~b + 1; the +1 comes from m entering as carry-in.
    assign b_eff      = b_reg ^ {WIDTH{m_reg}};
    assign sum_full   = {1'b0, a_reg} + {1'b0, b_eff} + {{WIDTH{1'b0}}, m_reg};
    assign sum_next   = sum_full[WIDTH-1:0];
    assign carry_next = sum_full[WIDTH];
    // Overflow: effective operands share a sign but the sum's sign differs.
    assign ovf_next   = (a_reg[WIDTH-1] == b_eff[WIDTH-1]) &&
                        (sum_next[WIDTH-1] != a_reg[WIDTH-1]);

`ifdef ADDSUB_SAT_EN
    // On overflow the true result lies beyond the range on a's side:
    // a >= 0 -> 0111..1, a < 0 -> 1000..0.
    assign s_next = ovf_next ? {a_reg[WIDTH-1], {(WIDTH-1){~a_reg[WIDTH-1]}}}
                             : sum_next;
`else
    assign s_next = sum_next;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            a_reg        <= '0;
            b_reg        <= '0;
            m_reg        <= 1'b0;
        end else if (s1_load) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                a_reg <= a;
                b_reg <= b;
                m_reg <= m;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg <= 1'b0;
            s_reg        <= '0;
            ovf_reg      <= 1'b0;
            carry_reg    <= 1'b0;
        end else if (s2_load) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s_reg     <= s_next;
                ovf_reg   <= ovf_next;
                carry_reg <= carry_next;
            end
        end
    end

    // Set has priority over clear so an overflow is never lost to a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_reg <= 1'b0;
        end else if (out_xfer && ovf_reg) begin
            sticky_reg <= 1'b1;
        end else if (clr_sticky) begin
            sticky_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (out_xfer) begin
            count_reg <= count_reg + 16'd1;
        end
    end

    assign out_valid  = s2_valid_reg;
    assign s          = s_reg;
    assign overflow   = ovf_reg;
    assign carry      = carry_reg;
    assign sticky_ovf = sticky_reg;
    assign op_count   = count_reg;

endmodule

// File: tb/tb_addsub_pipe.sv
// -----------------------------------------------------------------------------
// tb_addsub_pipe -- directed self-checking bench for addsub_pipe (WIDTH=8).
// Inputs are driven and outputs sampled on the falling clock edge, away from
// the rising edge that updates the design. Expected results are hand-computed
// constants; saturated variants apply when ADDSUB_SAT_EN is defined.
// -----------------------------------------------------------------------------
module tb_addsub_pipe;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic             m;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             overflow;
    logic             carry;
    logic             clr_sticky;
    logic             sticky_ovf;
    logic [15:0]      op_count;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_cnt = 16'd0;

    addsub_pipe #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .m          (m),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .s          (s),
        .overflow   (overflow),
        .carry      (carry),
        .clr_sticky (clr_sticky),
        .sticky_ovf (sticky_ovf),
        .op_count   (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // One operand set through an idle pipeline with out_ready high.
    // clr_at_out raises clr_sticky on the same cycle the result transfers.
    task automatic do_op(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                         input logic tm, input logic [7:0] es, input logic ec,
                         input logic eo, input logic clr_at_out, input logic e_sticky);
        @(negedge clk);
        check_val({tag, " in_ready"}, in_ready, 1);
        in_valid  = 1'b1;
        a         = ta;
        b         = tb;
        m         = tm;
        out_ready = 1'b1;
        @(negedge clk);                       // accepted at the rising edge between
        in_valid = 1'b0;
        check_val({tag, " valid_after_1"}, out_valid, 0);
        @(negedge clk);
        check_val({tag, " valid_after_2"}, out_valid, 1);
        check_val({tag, " s"}, s, es);
        check_val({tag, " carry"}, carry, ec);
        check_val({tag, " overflow"}, overflow, eo);
        clr_sticky = clr_at_out;
        @(negedge clk);                       // result transferred
        clr_sticky = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        check_val({tag, " valid_drop"}, out_valid, 0);
        check_val({tag, " sticky"}, sticky_ovf, e_sticky);
        check_val({tag, " op_count"}, op_count, exp_cnt);
    endtask

    // Stream vectors: a, b, m -> s
    logic [7:0] st_a [4] = '{8'h10, 8'h50, 8'hF0, 8'h05};
    logic [7:0] st_b [4] = '{8'h20, 8'h30, 8'h20, 8'h0A};
    logic       st_m [4] = '{1'b0,  1'b1,  1'b0,  1'b1};
    logic [7:0] st_s [4] = '{8'h30, 8'h20, 8'h10, 8'hFB};

    initial begin
        int in_idx;
        int out_idx;
        int acc;
        logic [7:0] e_s;

        rst_n = 1'b0; in_valid = 1'b0; m = 1'b0; a = '0; b = '0;
        out_ready = 1'b0; clr_sticky = 1'b0;

        // ---- Reset state ----
        repeat (2) @(negedge clk);
        check_val("rst out_valid", out_valid, 0);
        check_val("rst s", s, 0);
        check_val("rst op_count", op_count, 0);
        check_val("rst sticky", sticky_ovf, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("post-rst in_ready", in_ready, 1);

        // ---- Single operations ----
        do_op("ff+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef ADDSUB_SAT_EN
        e_s = 8'h7F;
`else
        e_s = 8'h80;
`endif
        do_op("7f+01", 8'h7F, 8'h01, 1'b0, e_s, 1'b0, 1'b1, 1'b0, 1'b1);
        // Clear sticky with an idle clr pulse
        @(negedge clk);
        clr_sticky = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0;
        check_val("sticky cleared", sticky_ovf, 0);
`ifdef ADDSUB_SAT_EN
        e_s = 8'h80;
`else
        e_s = 8'h7F;
`endif
        do_op("80-01", 8'h80, 8'h01, 1'b1, e_s, 1'b1, 1'b1, 1'b0, 1'b1);
`ifdef ADDSUB_SAT_EN
        e_s = 8'h7F;
`else
        e_s = 8'hA2;
`endif
        do_op("6c-ca", 8'h6C, 8'hCA, 1'b1, e_s, 1'b0, 1'b1, 1'b0, 1'b1);
        do_op("50-30", 8'h50, 8'h30, 1'b1, 8'h20, 1'b1, 1'b0, 1'b0, 1'b1);

        // ---- Back-pressured stream of 4 ----
        in_idx = 0; out_idx = 0;
        for (int cyc = 0; cyc < 40 && out_idx < 4; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 5);
            in_valid  = (in_idx < 4);
            if (in_idx < 4) begin
                a = st_a[in_idx]; b = st_b[in_idx]; m = st_m[in_idx];
            end
            #1;
            if (cyc >= 2 && cyc <= 4) begin
                check_val($sformatf("stall%0d in_ready", cyc), in_ready, 0);
                check_val($sformatf("stall%0d accepted", cyc), in_idx, 2);
                check_val($sformatf("stall%0d out_valid", cyc), out_valid, 1);
                check_val($sformatf("stall%0d s held", cyc), s, st_s[0]);
            end
            if (out_valid && out_ready) begin
                check_val($sformatf("stream s[%0d]", out_idx), s, st_s[out_idx]);
                out_idx++;
                exp_cnt = exp_cnt + 16'd1;
            end
            if (in_valid && in_ready) in_idx++;
        end
        check_val("stream outputs", out_idx, 4);
        @(negedge clk);
        in_valid = 1'b0;
        check_val("stream op_count", op_count, exp_cnt);

        // ---- Reset with both stages full ----
        out_ready = 1'b0;
        in_valid  = 1'b1; a = 8'h11; b = 8'h22; m = 1'b0;
        @(negedge clk);
        a = 8'h33;
        @(negedge clk);
        in_valid = 1'b0;
        check_val("full in_ready", in_ready, 0);
        rst_n = 1'b0;
        #1;
        check_val("async rst out_valid", out_valid, 0);
        check_val("async rst op_count", op_count, 0);
        check_val("async rst s", s, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        exp_cnt = 16'd0;
        repeat (3) @(negedge clk);
        check_val("no stale out_valid", out_valid, 0);
        check_val("no stale op_count", op_count, 0);

        // ---- op_count wrap: 65535 transfers, then one more ----
        acc = 0;
        in_valid = 1'b1; a = 8'h01; b = 8'h01; m = 1'b0;
        for (int i = 0; i < 70000; i++) begin
            #1;
            if (in_valid && in_ready) acc++;
            @(negedge clk);
            if (acc == 65535) break;
        end
        in_valid = 1'b0;
        check_val("preload accepted", acc, 65535);
        repeat (3) @(negedge clk);
        check_val("preload op_count", op_count, 16'hFFFF);
        // Clear sticky first so the coincident set is visible
        clr_sticky = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0;
        check_val("sticky pre-clear", sticky_ovf, 0);
        exp_cnt = 16'hFFFF;
`ifdef ADDSUB_SAT_EN
        e_s = 8'h7F;
`else
        e_s = 8'h80;
`endif
        do_op("wrap+clr", 8'h7F, 8'h01, 1'b0, e_s, 1'b0, 1'b1, 1'b1, 1'b1);
        check_val("wrap op_count zero", op_count, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
